// File: rtl/vga_mode_ctrl.sv
// Run-time VGA mode controller: holds H/V timing sets, applies mode changes at frame boundaries.
// Build option VGA_MODE_CTRL_MUTE_EN adds post-switch muting for MUTE_FRAMES frames.
module vga_mode_ctrl #(
  parameter int unsigned DEFAULT_MODE  = 2,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned MUTE_FRAMES   = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  input  logic [1:0]  req_mode,
  output logic        req_ready,
  input  logic        frame_end,
  output logic [1:0]  clk_sel,
  output logic [1:0]  mode,
  output logic [15:0] h_resolution,
  output logic [15:0] h_front_porch,
  output logic [15:0] h_sync,
  output logic [15:0] h_back_porch,
  output logic [15:0] v_resolution,
  output logic [15:0] v_front_porch,
  output logic [15:0] v_sync,
  output logic [15:0] v_back_porch,
  output logic        h_negative,
  output logic        v_negative,
  output logic        timing_enable,
  output logic        mute,
  output logic        busy
);

  if (DEFAULT_MODE > 3 || SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 ||
      MUTE_FRAMES < 1 || MUTE_FRAMES > 15) begin : g_bad_param
    $error("vga_mode_ctrl: parameter out of range");
  end

`ifdef VGA_MODE_CTRL_MUTE_EN
  typedef enum logic [1:0] {RUN, PEND, SWITCH, MUTE} state_t;
  localparam logic [3:0] MUTE_LAST = 4'(MUTE_FRAMES - 1);
`else
  typedef enum logic [1:0] {RUN, PEND, SWITCH} state_t;
`endif

  typedef struct packed {
    logic [15:0] h_res, h_fp, h_sync, h_bp;
    logic [15:0] v_res, v_fp, v_sync, v_bp;
    logic        h_neg, v_neg;
  } timing_t;

  localparam logic [1:0] DEF_MODE    = 2'(DEFAULT_MODE);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  function automatic timing_t mode_timing(input logic [1:0] m);
    case (m)
      2'd0:    mode_timing = '{16'd640,  16'd16,  16'd96,  16'd48,  16'd480, 16'd10, 16'd2, 16'd33, 1'b1, 1'b1};
      2'd1:    mode_timing = '{16'd800,  16'd40,  16'd128, 16'd88,  16'd600, 16'd1,  16'd4, 16'd23, 1'b0, 1'b0};
      2'd2:    mode_timing = '{16'd1280, 16'd110, 16'd40,  16'd220, 16'd720, 16'd5,  16'd5, 16'd20, 1'b0, 1'b0};
      default: mode_timing = '{16'd1024, 16'd24,  16'd136, 16'd160, 16'd768, 16'd3,  16'd6, 16'd29, 1'b1, 1'b1};
    endcase
  endfunction

  state_t     state_q, state_d;
  logic [1:0] mode_q, pend_mode;
  timing_t    tim_q;
  logic [7:0] settle_cnt;
`ifdef VGA_MODE_CTRL_MUTE_EN
  logic [3:0] frame_cnt;
`endif
  logic       ready_d, busy_d, mute_d, ten_d;
  logic       accept_new;

  assign accept_new = req_valid && req_ready && (req_mode != mode_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:    if (accept_new) state_d = PEND;
      PEND:   if (frame_end) state_d = SWITCH;
`ifdef VGA_MODE_CTRL_MUTE_EN
      SWITCH: if (settle_cnt == SETTLE_LAST) state_d = MUTE;
      MUTE:   if (frame_end && frame_cnt == MUTE_LAST) state_d = RUN;
`else
      SWITCH: if (settle_cnt == SETTLE_LAST) state_d = RUN;
`endif
      default: state_d = SWITCH;
    endcase
  end

  // Status outputs are decoded from the next state so the registered copies track state_q.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b1;
    mute_d  = 1'b1;
    ten_d   = 1'b1;
    case (state_d)
      RUN: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        mute_d  = 1'b0;
      end
      PEND:    mute_d = 1'b0;
      SWITCH:  ten_d  = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= SWITCH;
      req_ready     <= 1'b0;
      busy          <= 1'b1;
      mute          <= 1'b1;
      timing_enable <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_ready     <= ready_d;
      busy          <= busy_d;
      mute          <= mute_d;
      timing_enable <= ten_d;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      mode_q     <= DEF_MODE;
      pend_mode  <= DEF_MODE;
      tim_q      <= mode_timing(DEF_MODE);
      settle_cnt <= '0;
`ifdef VGA_MODE_CTRL_MUTE_EN
      frame_cnt  <= '0;
`endif
    end else begin
      case (state_q)
        RUN:  if (accept_new) pend_mode <= req_mode;
        PEND: if (frame_end) begin
          mode_q     <= pend_mode;
          tim_q      <= mode_timing(pend_mode);
          settle_cnt <= '0;
        end
        SWITCH: begin
          settle_cnt <= settle_cnt + 8'd1;
`ifdef VGA_MODE_CTRL_MUTE_EN
          if (settle_cnt == SETTLE_LAST) frame_cnt <= '0;
`endif
        end
`ifdef VGA_MODE_CTRL_MUTE_EN
        MUTE: if (frame_end) frame_cnt <= frame_cnt + 4'd1;
`endif
        default: ;
      endcase
    end
  end

  assign mode          = mode_q;
  assign clk_sel       = mode_q;
  assign h_resolution  = tim_q.h_res;
  assign h_front_porch = tim_q.h_fp;
  assign h_sync        = tim_q.h_sync;
  assign h_back_porch  = tim_q.h_bp;
  assign v_resolution  = tim_q.v_res;
  assign v_front_porch = tim_q.v_fp;
  assign v_sync        = tim_q.v_sync;
  assign v_back_porch  = tim_q.v_bp;
  assign h_negative    = tim_q.h_neg;
  assign v_negative    = tim_q.v_neg;

endmodule
